// File: rtl/rob_commit_unit.sv
// Reorder buffer with in-order multi-slot commit. Commit outputs are registered and appear one cycle after the retiring edge.
// Backpressure: alloc_ready drops when all DEPTH entries are occupied; commit and writeback are never stalled.
module rob_commit_unit #(
    parameter int DEPTH        = 8,
    parameter int COMMIT_WIDTH = 2,
    parameter int DATA_W       = 32,
    parameter int REG_W        = 4,
    parameter int TAG_W        = 3
) (
    input  logic                           clk1,
    input  logic                           rst,
    input  logic                           alloc_valid,
    input  logic                           alloc_has_dest,
    input  logic [REG_W-1:0]               alloc_dest_reg,
    output logic                           alloc_ready,
    output logic [TAG_W-1:0]               alloc_tag,
    input  logic                           wb_valid,
    input  logic [TAG_W-1:0]               wb_tag,
    input  logic [DATA_W-1:0]              wb_value,
    input  logic                           flush,
    output logic [COMMIT_WIDTH-1:0]        commit_valid,
    output logic [COMMIT_WIDTH-1:0]        commit_we,
    output logic [COMMIT_WIDTH*REG_W-1:0]  commit_reg,
    output logic [COMMIT_WIDTH*TAG_W-1:0]  commit_tag,
    output logic [COMMIT_WIDTH*DATA_W-1:0] commit_value,
    output logic [TAG_W:0]                 count,
    output logic                           empty,
    output logic                           full,
    output logic [31:0]                    cycle_count
);

    logic [DEPTH-1:0]             ent_valid;
    logic [DEPTH-1:0]             ent_done;
    logic [DEPTH-1:0]             ent_has_dest;
    logic [DEPTH-1:0][REG_W-1:0]  ent_reg;
    logic [DEPTH-1:0][DATA_W-1:0] ent_value;

    logic [TAG_W-1:0] head_q;
    logic [TAG_W-1:0] tail_q;
    logic [TAG_W:0]   count_q;
    logic [31:0]      cycle_q;

    logic             alloc_fire;
    logic [DEPTH-1:0] alloc_hit;
    logic [DEPTH-1:0] wb_hit;
    logic [DEPTH-1:0] ret_hit;
    logic [TAG_W:0]   n_ret;
    logic [TAG_W-1:0] slot_idx;
    logic             chain;

    logic [COMMIT_WIDTH-1:0]        cv_d;
    logic [COMMIT_WIDTH-1:0]        cwe_d;
    logic [COMMIT_WIDTH*REG_W-1:0]  creg_d;
    logic [COMMIT_WIDTH*TAG_W-1:0]  ctag_d;
    logic [COMMIT_WIDTH*DATA_W-1:0] cval_d;

    logic [COMMIT_WIDTH-1:0]        cv_q;
    logic [COMMIT_WIDTH-1:0]        cwe_q;
    logic [COMMIT_WIDTH*REG_W-1:0]  creg_q;
    logic [COMMIT_WIDTH*TAG_W-1:0]  ctag_q;
    logic [COMMIT_WIDTH*DATA_W-1:0] cval_q;

    // Space is judged on registered occupancy only; a same-edge retire does not open a slot.
    assign full        = (count_q == (TAG_W+1)'(DEPTH));
    assign empty       = (count_q == '0);
    assign alloc_ready = !full;
    assign alloc_tag   = tail_q;
    assign alloc_fire  = alloc_valid && alloc_ready && !flush;

    always_comb begin
        alloc_hit = '0;
        wb_hit    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            alloc_hit[i] = alloc_fire && (tail_q == TAG_W'(i));
            wb_hit[i]    = wb_valid && (wb_tag == TAG_W'(i)) && ent_valid[i] && !ent_done[i];
        end
    end

    // A slot retires only if every older slot in this window also retires.
    always_comb begin
        ret_hit  = '0;
        n_ret    = '0;
        slot_idx = '0;
        chain    = 1'b1;
        cv_d     = '0;
        cwe_d    = '0;
        creg_d   = '0;
        ctag_d   = '0;
        cval_d   = '0;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            slot_idx = head_q + TAG_W'(k);
            chain    = chain && ent_valid[slot_idx] && ent_done[slot_idx];
            if (chain) begin
                ret_hit[slot_idx]             = 1'b1;
                n_ret                         = n_ret + (TAG_W+1)'(1);
                cv_d[k]                       = 1'b1;
                cwe_d[k]                      = ent_has_dest[slot_idx];
                creg_d[k*REG_W +: REG_W]      = ent_reg[slot_idx];
                ctag_d[k*TAG_W +: TAG_W]      = slot_idx;
                cval_d[k*DATA_W +: DATA_W]    = ent_value[slot_idx];
            end
        end
    end

    always_ff @(posedge clk1) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst || flush) begin
                ent_valid[i] <= 1'b0;
                ent_done[i]  <= 1'b0;
            end else if (alloc_hit[i]) begin
                ent_valid[i] <= 1'b1;
                ent_done[i]  <= 1'b0;
            end else if (ret_hit[i]) begin
                ent_valid[i] <= 1'b0;
                ent_done[i]  <= 1'b0;
            end else if (wb_hit[i]) begin
                ent_done[i]  <= 1'b1;
            end
        end
    end

    // Payload needs no reset: it is only observed through valid/done.
    always_ff @(posedge clk1) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (alloc_hit[i]) begin
                ent_has_dest[i] <= alloc_has_dest;
                ent_reg[i]      <= alloc_dest_reg;
            end
            if (wb_hit[i]) begin
                ent_value[i] <= wb_value;
            end
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            cycle_q <= '0;
            cv_q    <= '0;
            cwe_q   <= '0;
            creg_q  <= '0;
            ctag_q  <= '0;
            cval_q  <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (flush) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
                cv_q    <= '0;
                cwe_q   <= '0;
                creg_q  <= '0;
                ctag_q  <= '0;
                cval_q  <= '0;
            end else begin
                tail_q  <= tail_q + TAG_W'(alloc_fire);
                head_q  <= TAG_W'((TAG_W+1)'(head_q) + n_ret);
                count_q <= count_q + (TAG_W+1)'(alloc_fire) - n_ret;
                cv_q    <= cv_d;
                cwe_q   <= cwe_d;
                creg_q  <= creg_d;
                ctag_q  <= ctag_d;
                cval_q  <= cval_d;
            end
        end
    end

    assign commit_valid = cv_q;
    assign commit_we    = cwe_q;
    assign commit_reg   = creg_q;
    assign commit_tag   = ctag_q;
    assign commit_value = cval_q;
    assign count        = count_q;
    assign cycle_count  = cycle_q;

endmodule

// File: tb/tb_rob_commit_unit.sv
// Bench for rob_commit_unit: queue-based reference model checked every cycle, plus literal spot checks
// and a single-slot-commit instance exercised with a short directed sequence.
module tb_rob_commit_unit;

    localparam int DEPTH = 8;
    localparam int CW    = 2;
    localparam int DW    = 32;
    localparam int RW    = 4;
    localparam int TW    = 3;

    logic clk1;
    logic rst;

    logic          alloc_valid, alloc_has_dest, alloc_ready;
    logic [RW-1:0] alloc_dest_reg;
    logic [TW-1:0] alloc_tag;
    logic          wb_valid;
    logic [TW-1:0] wb_tag;
    logic [DW-1:0] wb_value;
    logic          flush;
    logic [CW-1:0]    commit_valid, commit_we;
    logic [CW*RW-1:0] commit_reg;
    logic [CW*TW-1:0] commit_tag;
    logic [CW*DW-1:0] commit_value;
    logic [TW:0]      count;
    logic             empty, full;
    logic [31:0]      cycle_count;

    logic          b_alloc_valid, b_alloc_has_dest, b_alloc_ready;
    logic [RW-1:0] b_alloc_dest_reg;
    logic [TW-1:0] b_alloc_tag;
    logic          b_wb_valid;
    logic [TW-1:0] b_wb_tag;
    logic [DW-1:0] b_wb_value;
    logic          b_flush;
    logic [0:0]    b_commit_valid, b_commit_we;
    logic [RW-1:0] b_commit_reg;
    logic [TW-1:0] b_commit_tag;
    logic [DW-1:0] b_commit_value;
    logic [TW:0]   b_count;
    logic          b_empty, b_full;
    logic [31:0]   b_cycle_count;

    rob_commit_unit #(.DEPTH(DEPTH), .COMMIT_WIDTH(CW), .DATA_W(DW), .REG_W(RW), .TAG_W(TW)) u_dut (
        .clk1(clk1), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_has_dest(alloc_has_dest), .alloc_dest_reg(alloc_dest_reg),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value), .flush(flush),
        .commit_valid(commit_valid), .commit_we(commit_we), .commit_reg(commit_reg),
        .commit_tag(commit_tag), .commit_value(commit_value),
        .count(count), .empty(empty), .full(full), .cycle_count(cycle_count)
    );

    rob_commit_unit #(.DEPTH(DEPTH), .COMMIT_WIDTH(1), .DATA_W(DW), .REG_W(RW), .TAG_W(TW)) u_dut1 (
        .clk1(clk1), .rst(rst),
        .alloc_valid(b_alloc_valid), .alloc_has_dest(b_alloc_has_dest), .alloc_dest_reg(b_alloc_dest_reg),
        .alloc_ready(b_alloc_ready), .alloc_tag(b_alloc_tag),
        .wb_valid(b_wb_valid), .wb_tag(b_wb_tag), .wb_value(b_wb_value), .flush(b_flush),
        .commit_valid(b_commit_valid), .commit_we(b_commit_we), .commit_reg(b_commit_reg),
        .commit_tag(b_commit_tag), .commit_value(b_commit_value),
        .count(b_count), .empty(b_empty), .full(b_full), .cycle_count(b_cycle_count)
    );

    initial begin
        clk1 = 1'b0;
        forever #5 clk1 = ~clk1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: entries kept oldest-first in a queue.
    typedef struct {
        int            tag;
        bit            has_dest;
        logic [RW-1:0] rg;
        bit            done;
        logic [DW-1:0] value;
    } ent_t;

    ent_t        q[$];
    int          mtail;
    logic [31:0] mcycle;
    bit          model_valid = 1'b0;
    int          m_n;
    bit          m_ready;
    ent_t        m_e;

    logic [CW-1:0]    exp_cv, exp_cwe;
    logic [CW*RW-1:0] exp_creg;
    logic [CW*TW-1:0] exp_ctag;
    logic [CW*DW-1:0] exp_cval;

    always @(posedge clk1) begin
        if (rst) begin
            q.delete();
            mtail       = 0;
            mcycle      = 32'd0;
            exp_cv      = '0;
            exp_cwe     = '0;
            exp_creg    = '0;
            exp_ctag    = '0;
            exp_cval    = '0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            mcycle   = mcycle + 32'd1;
            exp_cv   = '0;
            exp_cwe  = '0;
            exp_creg = '0;
            exp_ctag = '0;
            exp_cval = '0;
            if (flush) begin
                q.delete();
                mtail = 0;
            end else begin
                m_ready = (q.size() < DEPTH);
                m_n = 0;
                for (int k = 0; k < CW; k++) begin
                    if (m_n == k && k < q.size() && q[k].done) begin
                        exp_cv[k]              = 1'b1;
                        exp_cwe[k]             = q[k].has_dest;
                        exp_creg[k*RW +: RW]   = q[k].rg;
                        exp_ctag[k*TW +: TW]   = TW'(q[k].tag);
                        exp_cval[k*DW +: DW]   = q[k].value;
                        m_n++;
                    end
                end
                if (wb_valid) begin
                    foreach (q[i]) begin
                        if (q[i].tag == int'(wb_tag) && !q[i].done) begin
                            q[i].done  = 1'b1;
                            q[i].value = wb_value;
                        end
                    end
                end
                repeat (m_n) void'(q.pop_front());
                if (alloc_valid && m_ready) begin
                    m_e.tag      = mtail;
                    m_e.has_dest = alloc_has_dest;
                    m_e.rg       = alloc_dest_reg;
                    m_e.done     = 1'b0;
                    m_e.value    = '0;
                    q.push_back(m_e);
                    mtail = (mtail + 1) % DEPTH;
                end
            end
        end
    end

    always @(negedge clk1) begin
        if (model_valid) begin
            chk("count",        64'(count),        64'(q.size()));
            chk("alloc_tag",    64'(alloc_tag),    64'(mtail));
            chk("alloc_ready",  64'(alloc_ready),  64'(q.size() < DEPTH));
            chk("empty",        64'(empty),        64'(q.size() == 0));
            chk("full",         64'(full),         64'(q.size() == DEPTH));
            chk("cycle_count",  64'(cycle_count),  64'(mcycle));
            chk("commit_valid", 64'(commit_valid), 64'(exp_cv));
            chk("commit_we",    64'(commit_we),    64'(exp_cwe));
            chk("commit_reg",   64'(commit_reg),   64'(exp_creg));
            chk("commit_tag",   64'(commit_tag),   64'(exp_ctag));
            chk("commit_value", 64'(commit_value), 64'(exp_cval));
        end
    end

    task automatic tick;
        @(posedge clk1);
        #1;
    endtask

    task automatic idle_inputs;
        alloc_valid = 1'b0; alloc_has_dest = 1'b1; alloc_dest_reg = '0;
        wb_valid = 1'b0; wb_tag = '0; wb_value = '0; flush = 1'b0;
    endtask

    int pend[$];

    task automatic random_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            alloc_valid    = ($urandom_range(0, 9) < 6);
            alloc_has_dest = ($urandom_range(0, 3) != 0);
            alloc_dest_reg = RW'($urandom);
            pend = {};
            foreach (q[i]) if (!q[i].done) pend.push_back(q[i].tag);
            wb_valid = 1'b0;
            if (pend.size() > 0 && $urandom_range(0, 9) < 7) begin
                wb_valid = 1'b1;
                wb_tag   = TW'(pend[$urandom_range(0, pend.size() - 1)]);
            end else if ($urandom_range(0, 9) < 2) begin
                wb_valid = 1'b1;
                wb_tag   = TW'($urandom);
            end
            wb_value = $urandom;
            flush    = ($urandom_range(0, 99) == 0);
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        b_alloc_valid = 1'b0; b_alloc_has_dest = 1'b1; b_alloc_dest_reg = '0;
        b_wb_valid = 1'b0; b_wb_tag = '0; b_wb_value = '0; b_flush = 1'b0;
        tick();
        tick();
        chk("rst_cycle",  64'(cycle_count),  64'd0);
        chk("rst_empty",  64'(empty),        64'd1);
        chk("rst_ready",  64'(alloc_ready),  64'd1);
        chk("rst_commit", 64'(commit_valid), 64'd0);
        rst = 1'b0;

        // Single-slot instance: two done entries retire on consecutive edges.
        b_alloc_valid = 1'b1; b_alloc_dest_reg = 4'd7; tick();
        b_alloc_dest_reg = 4'd8; tick();
        b_alloc_valid = 1'b0;
        b_wb_valid = 1'b1; b_wb_tag = 3'd0; b_wb_value = 32'hA; tick();
        b_wb_tag = 3'd1; b_wb_value = 32'hB; tick();
        chk("w1_cv0",  64'(b_commit_valid), 64'd1);
        chk("w1_val0", 64'(b_commit_value), 64'hA);
        chk("w1_cnt0", 64'(b_count),        64'd1);
        b_wb_valid = 1'b0; tick();
        chk("w1_cv1",  64'(b_commit_valid), 64'd1);
        chk("w1_val1", 64'(b_commit_value), 64'hB);
        chk("w1_tag1", 64'(b_commit_tag),   64'd1);
        tick();
        chk("w1_cv2",  64'(b_commit_valid), 64'd0);
        chk("w1_cnt2", 64'(b_count),        64'd0);

        // Out-of-order writeback, paired retirement.
        chk("tag0", 64'(alloc_tag), 64'd0);
        alloc_valid = 1'b1; alloc_dest_reg = 4'd1; tick();
        chk("tag1", 64'(alloc_tag), 64'd1);
        alloc_dest_reg = 4'd2; tick();
        chk("tag2", 64'(alloc_tag), 64'd2);
        alloc_dest_reg = 4'd3; tick();
        alloc_valid = 1'b0;
        chk("cnt3", 64'(count), 64'd3);
        chk("model_cnt3", 64'(q.size()), 64'd3);
        wb_valid = 1'b1; wb_tag = 3'd1; wb_value = 32'h22; tick();
        wb_tag = 3'd0; wb_value = 32'h11; tick();
        chk("no_early_commit", 64'(commit_valid), 64'd0);
        wb_valid = 1'b0; tick();
        chk("pair_cv",  64'(commit_valid), 64'b11);
        chk("pair_reg", 64'(commit_reg),   64'h21);
        chk("pair_val", 64'(commit_value), 64'h00000022_00000011);
        chk("pair_cnt", 64'(count),        64'd1);
        tick();
        chk("pair_cv_off", 64'(commit_valid), 64'd0);

        // No-destination entry and duplicate writeback.
        alloc_valid = 1'b1; alloc_has_dest = 1'b0; alloc_dest_reg = 4'd5; tick();
        alloc_valid = 1'b0; alloc_has_dest = 1'b1;
        wb_valid = 1'b1; wb_tag = 3'd3; wb_value = 32'h33; tick();
        wb_value = 32'h44; tick();
        wb_tag = 3'd2; wb_value = 32'h55; tick();
        wb_valid = 1'b0; tick();
        chk("nd_cv",  64'(commit_valid), 64'b11);
        chk("nd_we",  64'(commit_we),    64'b01);
        chk("nd_tag", 64'(commit_tag),   64'h1A);
        chk("nd_val", 64'(commit_value), 64'h00000033_00000055);
        chk("model_nd_val", 64'(exp_cval), 64'h00000033_00000055);

        // Fill to full, hold allocation across a retirement.
        alloc_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            alloc_dest_reg = RW'(i);
            tick();
        end
        chk("full_flag",  64'(full),        64'd1);
        chk("full_ready", 64'(alloc_ready), 64'd0);
        chk("full_tag",   64'(alloc_tag),   64'd4);
        wb_valid = 1'b1; wb_tag = 3'd4; wb_value = 32'h99; tick();
        wb_valid = 1'b0; tick();
        chk("full_ret_cnt", 64'(count),              64'd7);
        chk("full_ret_cv",  64'(commit_valid),       64'b01);
        chk("full_ret_val", 64'(commit_value[31:0]), 64'h99);
        tick();
        chk("full_realloc", 64'(count), 64'd8);
        alloc_valid = 1'b0;

        // Flush with entries pending.
        flush = 1'b1; tick();
        flush = 1'b0;
        chk("flush_cnt",   64'(count),        64'd0);
        chk("flush_empty", 64'(empty),        64'd1);
        chk("flush_cv",    64'(commit_valid), 64'd0);
        chk("flush_tag",   64'(alloc_tag),    64'd0);

        random_cycles(600);

        // Reset in the middle of traffic.
        alloc_valid = 1'b1; tick(); tick();
        rst = 1'b1; tick();
        chk("mrst_cnt",   64'(count),        64'd0);
        chk("mrst_cycle", 64'(cycle_count),  64'd0);
        chk("mrst_cv",    64'(commit_valid), 64'd0);
        chk("mrst_ready", 64'(alloc_ready),  64'd1);
        rst = 1'b0;
        idle_inputs();

        random_cycles(300);
        repeat (12) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rob_commit_unit.md
Name: rob_commit_unit

Overview:
- Parametrised reorder buffer with in-order commit for the Tomasulo core. It generalises the single-entry, single-retire commit stage.
- Dispatch allocates an entry at the tail and receives a ROB tag. The CDB writes back results by tag.
- Up to COMMIT_WIDTH completed entries retire from the head per cycle and drive ARF write / RAT-clear ports.
- The block supports flush and keeps a free-running cycle counter.

Parameters:
DEPTH, 8, ROB entries; power of two, >=4
COMMIT_WIDTH, 2, max retirements per cycle; 1 or 2
DATA_W, 32, result width
REG_W, 4, architectural register index width
TAG_W, 3, ROB tag width; equals log2(DEPTH)

Ports:
clk1  input  1  single clock; all state updates on posedge
rst  input  1  synchronous, active-high reset
alloc_valid  input  1  dispatch requests an entry
alloc_has_dest  input  1  entry writes a register; 0 for stores/branches
alloc_dest_reg  input  REG_W  destination architectural register
alloc_ready  output  1  entry available (= !full)
alloc_tag  output  TAG_W  tag assigned if allocation fires this cycle (= tail)
wb_valid  input  1  CDB broadcast valid
wb_tag  input  TAG_W  CDB tag
wb_value  input  DATA_W  CDB result
flush  input  1  discard all entries
commit_valid  output  COMMIT_WIDTH  per-slot retire pulse; slot 0 = oldest
commit_we  output  COMMIT_WIDTH  slot writes ARF (valid & has_dest)
commit_reg  output  COMMIT_WIDTH*REG_W  per-slot destination register
commit_tag  output  COMMIT_WIDTH*TAG_W  per-slot tag; RAT clears mapping if it still holds this tag
commit_value  output  COMMIT_WIDTH*DATA_W  per-slot result
count  output  TAG_W+1  occupied entries
empty  output  1  count==0
full  output  1  count==DEPTH
cycle_count  output  32  cycles since reset

Behaviour:
- Decided: one clock, clk1; reset rst is synchronous and active-high.
- Reset value of every output:
  - All entry valid/done bits clear. head=tail=0, count=0.
  - commit_* all 0. cycle_count=0. alloc_ready=1, empty=1, full=0.
- Entry fields: valid, done, has_dest, dest_reg, value.
- Allocation:
  - Fires when alloc_valid & alloc_ready at an edge.
  - Writes the entry at tail with valid=1, done=0. tail increments mod DEPTH.
  - alloc_tag and alloc_ready come from registered state only. A retirement in the same cycle does not free space for a same-cycle allocation, so no allocation fires when full.
- Writeback:
  - wb_valid at an edge sets done=1 and stores value at wb_tag, only if that entry is valid and not done.
  - Writeback to an invalid or already-done entry is ignored.
  - Writeback and allocation to the same index in one edge cannot be legal; allocation wins.
- Commit:
  - At each edge, evaluate head+k (mod DEPTH) for k=0..COMMIT_WIDTH-1 using registered state.
  - Slot k retires only if slots 0..k-1 retire and entry head+k is valid & done. Retirement is strictly in order; no skipping.
  - Retired entries have valid cleared. head advances by the number retired, with wrap-around.
- commit outputs:
  - Registered; they pulse for exactly one cycle after the retiring edge.
  - Slots not retiring have commit_valid=0 and zeroed data.
- Latency: wb at edge E sets done. The earliest retire is edge E+1, and commit_valid is visible in the cycle after E+1. There is no CDB-to-commit bypass.
- count update each edge: count += alloc_fire − retired. Simultaneous allocate and retire are both counted.
- flush:
  - At an edge, flush clears all entries, sets head=tail=count=0, and zeroes commit_* next cycle.
  - Priority is above alloc/wb/commit. cycle_count is unaffected.
- rst has priority over flush. Reset mid-operation discards everything the same as at power-on.
- cycle_count increments every non-reset edge and wraps at 2^32.
- Pointer wrap: head/tail are TAG_W bits. Full and empty are distinguished by count, not pointer equality.

Test Plan:
- After reset, allocate 3 entries (regs 1,2,3) -> alloc_tag 0,1,2; count=3. wb tag1=0x22 then tag0=0x11 -> no commit until tag0 done; then slots 0 and 1 pulse together with reg1/0x11 and reg2/0x22; count=1.
- Fill all 8 entries -> full=1, alloc_ready=0. Hold alloc_valid while a retirement occurs -> no allocation that edge, allocation on the next edge.
- Run 20 alloc/wb/commit cycles with wrap-around -> tags cycle 0..7,0..; commit order equals allocation order; commit_value matches each wb.
- Entry with alloc_has_dest=0 completes -> commit_valid=1, commit_we=0. Duplicate wb to the same tag -> the first value is kept.
- With 5 entries pending, assert flush -> count=0, empty=1, no commit pulses, next alloc_tag=0. Assert rst mid-stream -> all outputs return to reset values and cycle_count=0.
- With COMMIT_WIDTH=1, two consecutive done entries -> retire on consecutive edges, one per cycle.
